// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO register file and sequencer for an external divider.
// MT/MF ops complete in IDLE; DIV/DIVU launch the divider, wait for its
// result (or a timeout) and commit quotient/remainder into LO/HI.
module hilo_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,        // active-high async reset
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_rs,
    input  logic [31:0] op_rt,
    output logic        op_ready,
    output logic        stall,
    output logic [31:0] mf_data,
    output logic        mf_valid,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_start,
    output logic        div_select,
    output logic [31:0] div_in1,
    output logic [31:0] div_in2,
    input  logic [31:0] div_lo,
    input  logic [31:0] div_hi,
    input  logic        div_dbz,
    input  logic        div_done,
    output logic        dbz_flag,
    output logic        timeout_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    localparam logic [2:0] OP_NOP0 = 3'b000;
    localparam logic [2:0] OP_DIV  = 3'b001;
    localparam logic [2:0] OP_DIVU = 3'b010;
    localparam logic [2:0] OP_MTHI = 3'b011;
    localparam logic [2:0] OP_MTLO = 3'b100;
    localparam logic [2:0] OP_MFHI = 3'b101;
    localparam logic [2:0] OP_MFLO = 3'b110;
    localparam logic [2:0] OP_NOP7 = 3'b111;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          is_nop;
    logic          is_div;
    logic          accept;
    logic          div_commit;

    // NOPs are always accepted so they never stall the front end
    assign is_nop     = (op_code == OP_NOP0) || (op_code == OP_NOP7);
    assign is_div     = (op_code == OP_DIV)  || (op_code == OP_DIVU);
    assign op_ready   = (state == S_IDLE) || is_nop;
    assign stall      = op_valid & ~op_ready;
    assign accept     = op_valid && (state == S_IDLE);
    assign div_start  = (state == S_LAUNCH);
    assign div_commit = (state == S_WAIT) && div_done && !div_dbz;

    // Sequencer: launch, wait for done or timeout, raise event pulses
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            dbz_flag    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            dbz_flag    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && is_div) state <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    state <= S_WAIT;
                    cnt   <= '0;
                end
                S_WAIT: begin
                    if (div_done) begin
                        state    <= S_IDLE;
                        dbz_flag <= div_dbz;
                    end else if (cnt == CNT_LAST) begin
                        state       <= S_IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Divider operands: captured at acceptance, held until the next divide
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            div_in1    <= '0;
            div_in2    <= '0;
            div_select <= 1'b0;
        end else if (accept && is_div) begin
            div_in1    <= op_rs;
            div_in2    <= op_rt;
            div_select <= (op_code == OP_DIV);
        end
    end

    // HI/LO: divider commit in WAIT, MT writes in IDLE (never both at once)
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (div_commit) begin
            hi <= div_hi;
            lo <= div_lo;
        end else if (accept && op_code == OP_MTHI) begin
            hi <= op_rs;
        end else if (accept && op_code == OP_MTLO) begin
            lo <= op_rs;
        end
    end

    // MF read port: one-cycle valid pulse, data held between reads
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mf_data  <= '0;
            mf_valid <= 1'b0;
        end else begin
            mf_valid <= accept && (op_code == OP_MFHI || op_code == OP_MFLO);
            if (accept && op_code == OP_MFHI) mf_data <= hi;
            if (accept && op_code == OP_MFLO) mf_data <= lo;
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed + random ops against a sequential HI/LO model.
// Expected MF data and event pulses go into a scoreboard queue; a monitor
// pops them whenever the DUT raises mf_valid / dbz_flag / timeout_err.
module tb_hilo_ctrl;

    localparam int TO = 8;
    localparam int EV_MF = 0, EV_DBZ = 1, EV_TO = 2;
    localparam logic [2:0] NOP0 = 3'b000, DIV = 3'b001, DIVU = 3'b010, MTHI = 3'b011,
                           MTLO = 3'b100, MFHI = 3'b101, MFLO = 3'b110, NOP7 = 3'b111;

    logic        clk;
    logic        rst_n, op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_rs, op_rt;
    logic        op_ready, stall, mf_valid;
    logic [31:0] mf_data, hi, lo, div_in1, div_in2, div_lo, div_hi;
    logic        div_start, div_select, div_dbz, div_done, dbz_flag, timeout_err;

    hilo_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
        .op_rs(op_rs), .op_rt(op_rt), .op_ready(op_ready), .stall(stall),
        .mf_data(mf_data), .mf_valid(mf_valid), .hi(hi), .lo(lo),
        .div_start(div_start), .div_select(div_select), .div_in1(div_in1),
        .div_in2(div_in2), .div_lo(div_lo), .div_hi(div_hi), .div_dbz(div_dbz),
        .div_done(div_done), .dbz_flag(dbz_flag), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int kind; logic [31:0] data; } ev_t;
    typedef struct { int mode; int lat; bit glitch; logic [31:0] a; logic [31:0] b; logic s; } ln_t;

    ev_t exp_q[$];
    ln_t launch_q[$];
    int  n_cmp = 0, n_bad = 0;

    // model state and settings for the next divide
    logic [31:0] m_hi, m_lo;
    int  resp_mode;   // 0 answer, 1 never answer (timeout), 2 hold until stray_go
    int  resp_lat;
    bit  resp_glitch;
    bit  stray_go;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic push_ev(input int kind, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // reference divide: plain 64-bit arithmetic, truncating toward zero
    function automatic void divref(input logic s, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
        longint na, nb;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = 32'(na / nb);
        r = 32'(na % nb);
    endfunction

    // present one op until accepted; apply its architectural effect to the model
    task automatic issue(input logic [2:0] code, input logic [31:0] rs, input logic [31:0] rt,
                         output int waited);
        logic [31:0] q, r;
        ln_t ln;
        op_valid = 1'b1; op_code = code; op_rs = rs; op_rt = rt;
        waited = 0;
        forever begin
            @(negedge clk);
            if (op_ready) break;
            chk("stall_high", {31'd0, stall}, 32'd1);
            waited++;
            if (waited > 40) begin bound_fail("accept"); break; end
        end
        chk("stall_low", {31'd0, stall}, 32'd0);
        case (code)
            MTHI: m_hi = rs;
            MTLO: m_lo = rs;
            MFHI: push_ev(EV_MF, m_hi);
            MFLO: push_ev(EV_MF, m_lo);
            DIV, DIVU: begin
                ln.mode = resp_mode; ln.lat = resp_lat; ln.glitch = resp_glitch;
                ln.a = rs; ln.b = rt; ln.s = (code == DIV);
                launch_q.push_back(ln);
                if (resp_mode == 1) push_ev(EV_TO, 32'd0);
                else if (resp_mode == 0) begin
                    if (rt == 32'd0) push_ev(EV_DBZ, 32'd0);
                    else begin
                        divref(code == DIV, rs, rt, q, r);
                        m_lo = q; m_hi = r;
                    end
                end
            end
            default: ;
        endcase
        @(posedge clk); #1;
        op_valid = 1'b0; op_code = MFHI;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        op_valid = 1'b0; op_code = MFHI;
        do begin
            @(negedge clk);
            n++;
        end while (!op_ready && n < 40);
        if (!op_ready) bound_fail("idle");
        @(posedge clk); #1;
    endtask

    // operands must match the model and stay put while the divide runs
    task automatic chk_hold(input ln_t ln);
        chk("div_in1_hold", div_in1, ln.a);
        chk("div_in2_hold", div_in2, ln.b);
        chk("div_sel_hold", {31'd0, div_select}, {31'd0, ln.s});
    endtask

    // divider stand-in: answers each launch according to its queued settings
    task automatic run_div();
        ln_t ln;
        logic [31:0] q, r;
        int g;
        ln = launch_q.pop_front();
        chk_hold(ln);
        if (ln.mode == 0 && ln.glitch) begin
            div_done = 1'b1; div_dbz = 1'b0; div_hi = $urandom; div_lo = $urandom;
        end
        @(negedge clk);
        div_done = 1'b0;
        chk("start_pulse_width", {31'd0, div_start}, 32'd0);
        if (ln.mode == 2) begin
            g = 0;
            while (!stray_go && g < 100) begin @(negedge clk); g++; end
            div_done = 1'b1; div_dbz = 1'b0; div_hi = 32'hDEADBEEF; div_lo = 32'hCAFEF00D;
            @(negedge clk);
            div_done = 1'b0;
        end else if (ln.mode == 1) begin
            for (int k = 1; k <= TO + 1; k++) begin
                if (k > 1) @(negedge clk);
                chk("timeout_timing", {31'd0, timeout_err}, (k == TO + 1) ? 32'd1 : 32'd0);
                if (k <= TO) chk_hold(ln);
            end
        end else begin
            chk_hold(ln);
            repeat (ln.lat) begin @(negedge clk); chk_hold(ln); end
            if (ln.b == 32'd0) begin
                div_dbz = 1'b1; div_hi = $urandom; div_lo = $urandom;
            end else begin
                divref(ln.s, ln.a, ln.b, q, r);
                div_dbz = 1'b0; div_hi = r; div_lo = q;
            end
            div_done = 1'b1;
            @(negedge clk);
            div_done = 1'b0; div_dbz = 1'b0;
        end
    endtask

    initial begin
        div_done = 1'b0; div_dbz = 1'b0; div_lo = '0; div_hi = '0;
        forever begin
            @(negedge clk);
            if (div_start && !rst_n) begin
                if (launch_q.size() == 0) bound_fail("unexpected_launch");
                else run_div();
            end
        end
    end

    // scoreboard monitor
    task automatic pop_check(input int kind, input logic [31:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_event: kind %0d data %h, none expected", kind, data);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            if (kind == EV_MF) chk("mf_data", data, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (mf_valid)    pop_check(EV_MF, mf_data);
        if (dbz_flag)    pop_check(EV_DBZ, 32'd0);
        if (timeout_err) pop_check(EV_TO, 32'd0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [2:0] c;
        logic [31:0] rs, rt;
        rst_n = 1'b1; op_valid = 1'b0; op_code = MFHI; op_rs = '0; op_rt = '0;
        m_hi = '0; m_lo = '0; resp_mode = 0; resp_lat = 0; resp_glitch = 0; stray_go = 0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", hi, 0);               chk("rst_lo", lo, 0);
        chk("rst_mf_data", mf_data, 0);     chk("rst_div_in1", div_in1, 0);
        chk("rst_div_in2", div_in2, 0);     chk("rst_div_start", {31'd0, div_start}, 0);
        chk("rst_div_sel", {31'd0, div_select}, 0);
        chk("rst_mf_valid", {31'd0, mf_valid}, 0);
        chk("rst_dbz", {31'd0, dbz_flag}, 0);
        chk("rst_timeout", {31'd0, timeout_err}, 0);
        chk("rst_ready", {31'd0, op_ready}, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;

        // DIVU 100/7, accepted on the first edge after reset release
        resp_lat = 2;
        issue(DIVU, 32'd100, 32'd7, w);
        chk("first_accept_wait", 32'(w), 0);
        wait_idle();
        chk("divu_hi", hi, 32'd2); chk("divu_lo", lo, 32'd14);
        issue(MFLO, 0, 0, w);
        wait_idle();
        chk("mflo_data", mf_data, 32'd14);

        // signed DIV -100/7
        issue(DIV, 32'hFFFFFF9C, 32'd7, w);
        wait_idle();
        chk("div_hi", hi, 32'hFFFFFFFE); chk("div_lo", lo, 32'hFFFFFFF2);

        // divide by zero keeps HI/LO
        issue(MTHI, 32'h55, 0, w);
        issue(DIVU, 32'd9, 32'd0, w);
        wait_idle();
        chk("dbz_hi", hi, 32'h55); chk("dbz_lo", lo, 32'hFFFFFFF2);

        // MFHI stalled across the divide: L + W1..W4
        resp_lat = 3;
        issue(DIV, 32'd1000, 32'd33, w);
        issue(MFHI, 0, 0, w);
        chk("mfhi_stall_cycles", 32'(w), 32'd5);
        @(negedge clk);
        chk("mfhi_valid", {31'd0, mf_valid}, 1); chk("mfhi_new_hi", mf_data, 32'd10);
        @(negedge clk);
        chk("mfhi_valid_drop", {31'd0, mf_valid}, 0);
        @(posedge clk); #1;

        // reset during WAIT, then a stray div_done
        resp_mode = 2;
        issue(DIVU, 32'd50, 32'd5, w);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1; m_hi = '0; m_lo = '0;
        @(negedge clk);
        chk("midrst_ready", {31'd0, op_ready}, 1);
        @(posedge clk); #1;
        rst_n = 1'b0; stray_go = 1'b1;
        repeat (3) @(negedge clk);
        chk("stray_hi", hi, 0); chk("stray_lo", lo, 0);
        chk("stray_ready", {31'd0, op_ready}, 1);
        stray_go = 1'b0; resp_mode = 0;
        @(posedge clk); #1;

        // MT followed immediately by MF
        issue(MTLO, 32'hA5A5A5A5, 0, w);
        issue(MFLO, 0, 0, w);
        issue(MTHI, 32'h12345678, 0, w);
        issue(MFHI, 0, 0, w);
        wait_idle();

        // timeout: ready and pulse exactly after TO wait cycles
        resp_mode = 1;
        issue(DIVU, 32'd7, 32'd3, w);
        resp_mode = 0;
        for (int k = 0; k <= TO + 1; k++) begin
            @(negedge clk);
            chk("to_ready", {31'd0, op_ready}, (k == TO + 1) ? 32'd1 : 32'd0);
        end
        chk("to_hi", hi, 32'h12345678); chk("to_lo", lo, 32'hA5A5A5A5);
        @(posedge clk); #1;

        // NOPs pass straight through while a divide is running
        resp_lat = 4;
        issue(DIVU, 32'd77, 32'd5, w);
        issue(NOP0, 0, 0, w);
        chk("nop0_no_stall", 32'(w), 0);
        issue(NOP7, 0, 0, w);
        chk("nop7_no_stall", 32'(w), 0);
        wait_idle();
        chk("nop_div_lo", lo, 32'd15);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            c  = 3'($urandom_range(0, 7));
            rs = ($urandom % 8 == 0) ? 32'h80000000 : $urandom;
            case ($urandom % 5)
                0:       rt = 32'd0;
                1:       rt = 32'hFFFFFFFF;
                2, 3:    rt = 32'($urandom_range(1, 100));
                default: rt = $urandom;
            endcase
            resp_mode   = ($urandom % 12 == 0) ? 1 : 0;
            resp_lat    = $urandom_range(0, 5);
            resp_glitch = ($urandom % 3 == 0);
            issue(c, rs, rt, w);
            if ((c == DIV || c == DIVU) && $urandom % 2 == 0)
                issue(($urandom % 2) ? MFHI : MFLO, 0, 0, w);
            if ($urandom % 4 == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("final_hi", hi, m_hi); chk("final_lo", lo, m_lo);
        chk("events_outstanding", 32'(exp_q.size()), 0);
        chk("launches_outstanding", 32'(launch_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
